alu_share_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared combinational ALU. It accepts operation requests from requester 0 (pipeline EX stage) and requester 1 (auxiliary unit, e.g. branch/address helper), picks a winner, drives the ALU from registered operands, and returns the captured result to the winner over a valid/ready response channel. It sits between the requesters and the ALU. The ALU itself stays external and combinational.

---
 rtl/alu_share_arb.sv | 138 +++++++++++++
 tb/tb_alu_share_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Two-requester arbiter/sequencer for a shared external combinational ALU.
// Optional ALU_SHARE_ARB_FIXED_PRIO_EN: requester 0 always wins ties.
module alu_share_arb #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [3:0]       req0_op,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             rsp_err
);

   localparam logic [3:0] OP_ADD = 4'b0010;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q, state_d;
   logic             id_q, id_d;
   logic             err_q, err_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             zero_q, zero_d;
   logic             rerr_q, rerr_d;
   logic             winner;
   logic             accept;
   logic [3:0]       sel_op;

   function automatic logic op_legal(input logic [3:0] op);
      return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0110);
   endfunction

`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
   assign winner = ~req_valid[0];
`else
   logic last_grant_q;

   // On a tie the requester not granted last wins; reset favours requester 0.
   assign winner = (&req_valid) ? ~last_grant_q : req_valid[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else if (accept) begin
         last_grant_q <= winner;
      end
   end
`endif

   assign accept    = (state_q == IDLE) && (|req_valid);
   assign req_ready = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;
   assign sel_op    = winner ? req1_op : req0_op;

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      err_d   = err_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      data_d  = data_q;
      zero_d  = zero_q;
      rerr_d  = rerr_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EXEC;
               id_d    = winner;
               err_d   = ~op_legal(sel_op);
               op_d    = op_legal(sel_op) ? sel_op : OP_ADD;
               a_d     = winner ? req1_a : req0_a;
               b_d     = winner ? req1_b : req0_b;
            end
         end
         EXEC: begin
            state_d = RESP;
            data_d  = alu_result;
            zero_d  = (alu_result == '0);
            rerr_d  = err_q;
         end
         RESP: begin
            if (rsp_ready[id_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         zero_q  <= 1'b0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         err_q   <= err_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
         rerr_q  <= rerr_d;
      end
   end

   // ALU inputs hold the last latched request outside EXEC.
   assign alu_ctrl  = op_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign rsp_valid = (state_q == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_data  = data_q;
   assign rsp_zero  = zero_q;
   assign rsp_err   = rerr_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with an ALU model and response scoreboard.
// Honours ALU_SHARE_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_alu_share_arb;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [3:0]   req0_op, req1_op, alu_ctrl;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_data;
   logic         rsp_zero, rsp_err;

   typedef struct {
      logic         id;
      logic [3:0]   ctrl;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] data;
      logic         zero;
      logic         err;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   grants[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always_comb begin
      case (alu_ctrl)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: alu_result = alu_a + alu_b;
         4'b0110: alu_result = alu_a - alu_b;
         default: alu_result = 32'hDEAD_BEEF;
      endcase
   end

   alu_share_arb #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_op(req0_op), .req1_op(req1_op),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic id);
      exp_t       e;
      logic [3:0] op;
      op     = id ? req1_op : req0_op;
      e.id   = id;
      e.a    = id ? req1_a : req0_a;
      e.b    = id ? req1_b : req0_b;
      e.err  = 1'b0;
      e.ctrl = op;
      case (op)
         4'b0000: e.data = e.a & e.b;
         4'b0001: e.data = e.a | e.b;
         4'b0010: e.data = e.a + e.b;
         4'b0110: e.data = e.a - e.b;
         default: begin
            e.data = e.a + e.b;
            e.err  = 1'b1;
            e.ctrl = 4'b0010;
         end
      endcase
      e.zero = (e.data == 0);
      e.acc  = cyc;
      sb.push_back(e);
      grants.push_back(int'(id));
   endtask

   task automatic check_exec();
      exp_t e;
      if (sb.size() == 0) begin
         chk("exec_pending", 0, 1);
      end else begin
         e = sb[sb.size()-1];
         chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.ctrl});
         chk("alu_a", alu_a, e.a);
         chk("alu_b", alu_b, e.b);
         chk("req_ready_exec", {30'd0, req_ready}, 0);
      end
   endtask

   task automatic check_rsp();
      exp_t e;
      if (sb.size() == 0) begin
         chk("rsp_unexpected", {30'd0, rsp_valid}, 0);
      end else begin
         e = sb.pop_front();
         chk("rsp_valid", {30'd0, rsp_valid}, e.id ? 2 : 1);
         chk("rsp_data", rsp_data, e.data);
         chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
         chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
         chk("rsp_latency", cyc - e.acc, 2);
      end
   endtask

   // Entered and left at posedge+1; requests sampled at posedge+2.
   task automatic service(input int ncyc, input bit drop, input logic [1:0] rdy);
      logic [1:0] acc;
      rsp_ready = rdy;
      for (int i = 0; i < ncyc; i++) begin
         #1;
         acc = req_ready;
         if (acc != 2'b00) push_exp(acc[1]);
         @(posedge clk); #1;
         if (acc != 2'b00) begin
            check_exec();
            if (drop) req_valid = req_valid & ~acc;
            else if (acc[1]) begin req1_a = req1_a + 32'h100; req1_b = req1_b + 2; end
            else begin req0_a = req0_a + 17; req0_b = req0_b + 5; end
         end
         if (rsp_valid != 2'b00) check_rsp();
      end
      rsp_ready = 2'b00;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_req_ready"}, {30'd0, req_ready}, 0);
      chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_rsp_zero"}, {31'd0, rsp_zero}, 0);
      chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 0);
      chk({tag, "_alu_ctrl"}, {28'd0, alu_ctrl}, 0);
      chk({tag, "_alu_a"}, alu_a, 0);
      chk({tag, "_alu_b"}, alu_b, 0);
   endtask

   initial begin
      int order[4];
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
      order = '{0, 0, 0, 0};
`else
      order = '{0, 1, 0, 1};
`endif
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
      req0_op = 4'd0; req1_op = 4'd0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_checks("por");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single ADD from requester 0
      req0_op = 4'b0010; req0_a = 5; req0_b = 7; req_valid = 2'b01;
      grants.delete();
      service(3, 1'b1, 2'b01);
      chk("t1_grants", grants.size(), 1);
      if (grants.size() > 0) chk("t1_winner", grants[0], 0);

      // SUB to zero from requester 1
      req1_op = 4'b0110; req1_a = 32'h1234; req1_b = 32'h1234; req_valid = 2'b10;
      grants.delete();
      service(3, 1'b1, 2'b10);
      chk("t2_grants", grants.size(), 1);
      if (grants.size() > 0) chk("t2_winner", grants[0], 1);

      // contention with both valid throughout
      req0_op = 4'b0010; req0_a = 100; req0_b = 1;
      req1_op = 4'b0001; req1_a = 32'h10; req1_b = 32'h3;
      req_valid = 2'b11;
      grants.delete();
      service(12, 1'b0, 2'b11);
      req_valid = 2'b00;
      chk("cont_grants", grants.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < grants.size()) chk($sformatf("cont_order%0d", k), grants[k], order[k]);

      // back-pressure on requester 0 with requester 1 waiting
      @(posedge clk); #1;
      req0_op = 4'b0000; req0_a = 32'hF0F0; req0_b = 32'h0FF0; req_valid = 2'b01;
      #1;
      chk("bp_req_ready", {30'd0, req_ready}, 1);
      push_exp(1'b0);
      @(posedge clk); #1;
      check_exec();
      req1_op = 4'b0001; req1_a = 1; req1_b = 2; req_valid = 2'b10;
      #1;
      chk("bp_exec_ready", {30'd0, req_ready}, 0);
      @(posedge clk); #1;
      check_rsp();
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", {30'd0, rsp_valid}, 1);
         chk("bp_hold_data", rsp_data, 32'h00F0);
         chk("bp_hold_ready", {30'd0, req_ready}, 0);
      end
      rsp_ready = 2'b01;
      @(posedge clk); #1;
      chk("bp_released", {30'd0, rsp_valid}, 0);
      chk("bp_r1_ready", {30'd0, req_ready}, 2);
      grants.delete();
      service(3, 1'b1, 2'b10);
      chk("bp_r1_grants", grants.size(), 1);

      // illegal op executes as ADD with err
      req0_op = 4'b1111; req0_a = 3; req0_b = 4; req_valid = 2'b01;
      service(3, 1'b1, 2'b01);

      // reset during EXEC
      req0_op = 4'b0010; req0_a = 1; req0_b = 1; req_valid = 2'b01;
      #1;
      chk("rm_accept", {30'd0, req_ready}, 1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      chk("rm_exec_ctrl", {28'd0, alu_ctrl}, 2);
      rst_n = 1'b0;
      #1;
      reset_checks("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      req0_op = 4'b0010; req0_a = 9; req0_b = 9;
      req1_op = 4'b0110; req1_a = 9; req1_b = 9;
      req_valid = 2'b11;
      grants.delete();
      service(6, 1'b1, 2'b11);
      chk("rm_grants", grants.size(), 2);
      if (grants.size() > 1) begin
         chk("rm_first", grants[0], 0);
         chk("rm_second", grants[1], 1);
      end
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
